// File: rtl/ofl_pkg.sv
// Shared types and sizing helpers for the open free-list packet reader.
package ofl_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Default geometry: 128-bit lines, 64 KB buffer, 128 B chunks
    localparam int OFL_RAM_W = 128;
    localparam int OFL_RAM_S = 64;
    localparam int OFL_CNK_S = 128;
    localparam int OFL_BPL   = OFL_RAM_W / 8;
    localparam int OFL_CN_W  = clog2(OFL_RAM_S * 1024 / OFL_CNK_S);
    localparam int OFL_MOD_W = clog2(OFL_BPL);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        REL
    } rd_state_t;

    // ceil(len / 2**lbpl) with a guard bit so len + BPL - 1 cannot wrap
    function automatic logic [31:0] pkt_lines(
        input logic [31:0] len,
        input int          lbpl
    );
        logic [32:0] s;
        s = {1'b0, len} + (33'd1 << lbpl) - 33'd1;
        s = s >> lbpl;
        return s[31:0];
    endfunction

    function automatic logic [31:0] pkt_mod(
        input logic [31:0] len,
        input int          lbpl
    );
        return len & ((32'd1 << lbpl) - 32'd1);
    endfunction

endpackage

// File: rtl/ofl_desc_slice.sv
// One-entry descriptor register: head chunk, last-line byte count and
// the remaining-line counter for the packet in flight.
module ofl_desc_slice
    import ofl_pkg::*;
#(
    parameter int CN_W  = 9,
    parameter int LEN_W = 16,
    parameter int MOD_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             take,
    input  logic             pop,
    input  logic [CN_W-1:0]  desc_chunk,
    input  logic [LEN_W-1:0] desc_len,
    output logic [CN_W-1:0]  chunk,
    output logic [MOD_W-1:0] mod,
    output logic             last
);

    localparam int LW = LEN_W + 1;

    logic [LW-1:0]    remaining;
    logic [LW-1:0]    lines;
    logic [MOD_W-1:0] mod_d;
    logic [31:0]      lines_w;
    logic [31:0]      mod_w;

    assign lines_w = pkt_lines(32'(desc_len), MOD_W);
    assign mod_w   = pkt_mod(32'(desc_len), MOD_W);
    assign lines   = lines_w[LW-1:0];
    assign mod_d   = mod_w[MOD_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chunk     <= '0;
            mod       <= '0;
            remaining <= '0;
        end else if (take) begin
            chunk     <= desc_chunk;
            mod       <= mod_d;
            remaining <= lines;
        end else if (pop && (remaining != '0)) begin
            remaining <= remaining - LW'(1);
        end
    end

    assign last = (remaining == LW'(1));

endmodule

// File: rtl/ofl_pkt_reader.sv
// Read-side initiator for the open free-list packet buffer.
// Define OFL_RD_DROP_EN to let desc_drop release a chain without reading it.
module ofl_pkt_reader
    import ofl_pkg::*;
#(
    parameter int RAM_W = 128,
    parameter int RAM_E = 0,
    parameter int RAM_S = 64,
    parameter int CNK_S = 128,
    parameter int LEN_W = 16,
    localparam int CN_W  = clog2(RAM_S * 1024 / CNK_S),
    localparam int MOD_W = clog2(RAM_W / 8),
    localparam int DW    = RAM_W + RAM_E
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [CN_W-1:0]  desc_chunk,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             desc_drop,
    output logic [CN_W-1:0]  chunk_num,
    output logic             load_req,
    output logic             rel_req,
    input  logic             load_rel_ack,
    output logic             rden,
    input  logic [DW-1:0]    dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic [MOD_W-1:0] out_mod
);

    rd_state_t state;
    rd_state_t next;
    logic      accept;
    logic      skip;
    logic      last;

    assign desc_ready = (state == IDLE) && !reset;
    assign accept     = desc_valid && desc_ready;

`ifdef OFL_RD_DROP_EN
    assign skip = (desc_len == '0) || desc_drop;
`else
    logic unused_drop;
    assign unused_drop = desc_drop;
    assign skip        = (desc_len == '0);
`endif

    assign out_valid = (state == STREAM);
    assign rden      = out_valid && out_ready;
    assign out_last  = out_valid && last;
    assign out_data  = dout;

    ofl_desc_slice #(
        .CN_W  (CN_W),
        .LEN_W (LEN_W),
        .MOD_W (MOD_W)
    ) u_slice (
        .clk        (clk),
        .reset      (reset),
        .take       (accept),
        .pop        (rden),
        .desc_chunk (desc_chunk),
        .desc_len   (desc_len),
        .chunk      (chunk_num),
        .mod        (out_mod),
        .last       (last)
    );

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next = skip ? REL : LOAD;
                end
            end
            LOAD: begin
                if (load_rel_ack) begin
                    next = STREAM;
                end
            end
            STREAM: begin
                if (rden && last) begin
                    next = REL;
                end
            end
            REL: begin
                if (load_rel_ack) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Requests are flops so the buffer sees clean edges it can detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            load_req <= 1'b0;
            rel_req  <= 1'b0;
        end else begin
            state    <= next;
            load_req <= (next == LOAD);
            rel_req  <= (next == REL);
        end
    end

endmodule

// File: tb/tb_ofl_pkt_reader.sv
// Randomised bench for ofl_pkt_reader with a packet-level reference model.
module tb_ofl_pkt_reader;

    localparam int CN_W  = 9;
    localparam int LEN_W = 16;
    localparam int MOD_W = 4;
    localparam int DW    = 128;
    localparam int BPL   = 16;

`ifdef OFL_RD_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             desc_valid;
    logic             desc_ready;
    logic [CN_W-1:0]  desc_chunk;
    logic [LEN_W-1:0] desc_len;
    logic             desc_drop;
    logic [CN_W-1:0]  chunk_num;
    logic             load_req;
    logic             rel_req;
    logic             load_rel_ack;
    logic             rden;
    logic [DW-1:0]    dout;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic [MOD_W-1:0] out_mod;

    ofl_pkt_reader dut (
        .clk          (clk),
        .reset        (reset),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .desc_chunk   (desc_chunk),
        .desc_len     (desc_len),
        .desc_drop    (desc_drop),
        .chunk_num    (chunk_num),
        .load_req     (load_req),
        .rel_req      (rel_req),
        .load_rel_ack (load_rel_ack),
        .rden         (rden),
        .dout         (dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_mod      (out_mod)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pid   = 0;
    int mode  = 0;
    int dly_load = 0;
    int dly_rel  = 0;

    // model state
    int ph = 0;
    int m_chunk, m_lines, m_mod, m_pid, popped;
    int pkt_pops = 0;
    int rel_cycles = 0;
    int last_mod_seen = -1;
    int done_cnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mkline(input int c, input int i, input int p);
        return {32'(c) ^ 32'hC0DE_0000, 32'(i), 32'(p), 32'h5A5A_5A5A ^ 32'(i * 7)};
    endfunction

    // sink readiness
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'(($urandom_range(0, 1)));
            endcase
        end
    end

    // buffer model: delayed single-cycle ack, show-ahead lines
    initial begin : buffer
        logic s_rden, s_lr;
        int   s_chunk, bchunk, bidx, wcnt;
        load_rel_ack = 1'b0;
        dout   = '0;
        bchunk = 0;
        bidx   = 0;
        wcnt   = 0;
        forever begin
            @(negedge clk);
            s_rden  = rden;
            s_lr    = load_req;
            s_chunk = int'(chunk_num);
            @(posedge clk);
            #1;
            if (reset) begin
                load_rel_ack = 1'b0;
                wcnt = 0;
            end else if (load_rel_ack) begin
                load_rel_ack = 1'b0;
                wcnt = 0;
                if (s_lr) begin
                    bchunk = s_chunk;
                    bidx   = 0;
                    dout   = mkline(bchunk, bidx, pid);
                end
            end else begin
                if (s_rden) begin
                    bidx = bidx + 1;
                    dout = mkline(bchunk, bidx, pid);
                end
                if (load_req || rel_req) begin
                    if (wcnt >= (load_req ? dly_load : dly_rel))
                        load_rel_ack = 1'b1;
                    else
                        wcnt = wcnt + 1;
                end
            end
        end
    end

    // compare process: expected outputs from the packet-level model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                chk1("rst_ready", desc_ready, 1'b0);
                chk1("rst_load", load_req, 1'b0);
                chk1("rst_rel", rel_req, 1'b0);
                chk1("rst_valid", out_valid, 1'b0);
                chk1("rst_rden", rden, 1'b0);
                chk1("rst_last", out_last, 1'b0);
                chkv("rst_chunk", 128'(chunk_num), 128'(0));
                chkv("rst_mod", 128'(out_mod), 128'(0));
                ph = 0;
            end else begin
                chk1("desc_ready", desc_ready, ph == 0);
                chk1("load_req", load_req, ph == 1);
                chk1("rel_req", rel_req, ph == 3);
                chk1("out_valid", out_valid, ph == 2);
                chk1("rden", rden, (ph == 2) && out_ready);
                if (ph != 0)
                    chkv("chunk_num", 128'(chunk_num), 128'(m_chunk));
                if (ph == 2) begin
                    chk1("out_last", out_last, popped == m_lines - 1);
                    if (popped == m_lines - 1)
                        chkv("out_mod", 128'(out_mod), 128'(m_mod));
                    chkv("out_data", out_data, mkline(m_chunk, popped, m_pid));
                end else begin
                    chk1("last_idle", out_last, 1'b0);
                end
                if (ph == 3)
                    rel_cycles++;
                case (ph)
                    0: if (desc_valid) begin
                        m_chunk  = int'(desc_chunk);
                        m_lines  = (int'(desc_len) + BPL - 1) / BPL;
                        m_mod    = int'(desc_len) % BPL;
                        m_pid    = pid;
                        popped   = 0;
                        pkt_pops = 0;
                        rel_cycles = 0;
                        last_mod_seen = -1;
                        if (desc_len == 0 || (desc_drop && DROP_EN))
                            ph = 3;
                        else
                            ph = 1;
                    end
                    1: if (load_rel_ack) ph = 2;
                    2: if (out_ready) begin
                        if (popped == m_lines - 1)
                            last_mod_seen = int'(out_mod);
                        popped++;
                        pkt_pops++;
                        if (popped == m_lines)
                            ph = 3;
                    end
                    3: if (load_rel_ack) begin
                        ph = 0;
                        done_cnt++;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic send(input int c, input int l, input bit d);
        int n;
        @(posedge clk);
        #1;
        pid++;
        desc_chunk = CN_W'(c);
        desc_len   = LEN_W'(l);
        desc_drop  = d;
        desc_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!desc_ready && n < 500);
        if (!desc_ready)
            chk1("accept_timeout", desc_ready, 1'b1);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk1("done_timeout", done_cnt != start, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, len, c;
        bit d;
        reset      = 1'b1;
        desc_valid = 1'b0;
        desc_chunk = '0;
        desc_len   = '0;
        desc_drop  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        mode = 0;
        send(5, 64, 1'b0);
        wait_done();
        chkv("t1_pops", 128'(pkt_pops), 128'(4));
        chkv("t1_mod", 128'(last_mod_seen), 128'(0));
        chkv("t1_rel", 128'(rel_cycles), 128'(1));

        send(6, 37, 1'b0);
        wait_done();
        chkv("t2_pops", 128'(pkt_pops), 128'(3));
        chkv("t2_mod", 128'(last_mod_seen), 128'(5));

        mode = 1;
        send(7, 300, 1'b0);
        wait_done();
        chkv("t3_pops", 128'(pkt_pops), 128'(19));
        chkv("t3_mod", 128'(last_mod_seen), 128'(12));

        mode = 0;
        dly_rel = 10;
        send(8, 40, 1'b0);
        wait_done();
        chkv("t4_rel", 128'(rel_cycles), 128'(11));
        dly_rel = 0;

        send(9, 500, 1'b1);
        wait_done();
        chkv("t5_pops", 128'(pkt_pops), 128'(DROP_EN ? 0 : 32));
        chkv("t5_chunk", 128'(chunk_num), 128'(9));

        send(10, 0, 1'b0);
        wait_done();
        chkv("t6_pops", 128'(pkt_pops), 128'(0));

        send(11, 16, 1'b0);
        wait_done();
        chkv("t7_pops", 128'(pkt_pops), 128'(1));
        send(12, 17, 1'b0);
        wait_done();
        chkv("t8_mod", 128'(last_mod_seen), 128'(1));
        send(13, 128, 1'b0);
        wait_done();
        chkv("t9_pops", 128'(pkt_pops), 128'(8));
        send(14, 65535, 1'b0);
        wait_done();
        chkv("t10_pops", 128'(pkt_pops), 128'(4096));
        chkv("t10_mod", 128'(last_mod_seen), 128'(15));

        // reset in the middle of a stream
        send(3, 400, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_valid", out_valid, 1'b0);
        chk1("arst_rden", rden, 1'b0);
        chk1("arst_load", load_req, 1'b0);
        chk1("arst_rel", rel_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_ready", desc_ready, 1'b1);

        mode = 2;
        for (int i = 0; i < 30; i++) begin
            dly_load = $urandom_range(0, 4);
            dly_rel  = $urandom_range(0, 6);
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 600);
            d   = ($urandom_range(0, 3) == 0);
            c   = $urandom_range(0, 511);
            send(c, len, d);
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
